// File: rtl/da_cache_pkg.sv
// da_cache_pkg
// Shared constants and types for the DAC sample cache.
//   DA_CHE_ADDR_NBIT : log2 of entries per ping-pong half
//   DA_CHE_DATA_NBIT : cache entry width (two 24-bit sample slots)
//   DA_DATA_NBIT     : DAC sample width
//   USB_DATA_NBIT    : host word width
//   rd_state_e       : read/playback FSM state encodings
package da_cache_pkg;

  localparam int DA_CHE_ADDR_NBIT = 8;
  localparam int DA_CHE_DATA_NBIT = 48;
  localparam int DA_DATA_NBIT     = 16;
  localparam int USB_DATA_NBIT    = 16;
  localparam int SLOT_NBIT        = DA_CHE_DATA_NBIT / 2;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_PLAY  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/da_cache_pingpong_ram.sv
// pingpong_ram
// Simple dual-port entry store for both cache halves; the MSB of each
// address selects the half. Registered read (1 cycle latency), no reset.
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr    : read port; rdata holds its value while re is low
//   rdata       : read data
module pingpong_ram #(
  parameter int AW = 9,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/da_cache.sv
// da_cache
// Ping-pong cache between a 16-bit host word stream and a DAC sample stream.
// Three host words pack into one 48-bit entry holding two sample slots.
// One half is filled while the other is played.
// Optional build macro: DA_CHE_REPEAT_EN -- when a half finishes playing and
// the other half is not loaded, replay the same half instead of going idle.
//
// Read FSM states:
//   RD_IDLE  | nothing to play; rd returns 0 and flags underflow
//   RD_FETCH | RAM read of the current entry in flight
//   RD_PLAY  | entry available; rd returns slot 0 then slot 1
//
// Ports:
//   clk, rst          : clock, async active-high reset
//   en                : enable; low flushes everything
//   wr, wdata, wready : host word input, wready high while a half is free
//   rd                : sample request (>= 3 cycles apart)
//   rdata, rvalid     : sample out, valid 2 cycles after rd
//   switch            : half currently being played
//   underflow, overrun: sticky error flags
module da_cache
  import da_cache_pkg::*;
#(
  parameter int CHE_ADDR_NBIT = DA_CHE_ADDR_NBIT,
  parameter int DA_DATA_NBIT  = da_cache_pkg::DA_DATA_NBIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr,
  input  logic [USB_DATA_NBIT-1:0] wdata,
  output logic                     wready,
  input  logic                     rd,
  output logic [DA_DATA_NBIT-1:0]  rdata,
  output logic                     rvalid,
  output logic                     switch,
  output logic                     underflow,
  output logic                     overrun
);

  // write side
  logic [1:0]                    pack_cnt;
  logic [2*USB_DATA_NBIT-1:0]    pack_buf;
  logic [DA_CHE_DATA_NBIT-1:0]   wr_entry;
  logic                          wr_pend;
  logic [CHE_ADDR_NBIT-1:0]      wr_addr;
  logic                          wr_half;
  logic [1:0]                    loaded;
  logic [1:0]                    loaded_nxt;

  // read side
  rd_state_e                     state;
  logic [CHE_ADDR_NBIT-1:0]      rd_addr;
  logic                          slot_sel;
  logic                          s1_valid;
  logic [DA_DATA_NBIT-1:0]       s1_data;
  logic [DA_CHE_DATA_NBIT-1:0]   ram_q;
  logic [SLOT_NBIT-1:0]          slot;

  logic wr_half_done, play_rd, half_done, other_loaded, release_half;
  logic eff_loaded0, eff_loaded1;

  assign wr_half_done = wr_pend && (wr_addr == '1);
  assign play_rd      = rd && (state == RD_PLAY);
  assign half_done    = play_rd && slot_sel && (rd_addr == '1);
  // A half completing this very cycle counts as loaded so playback can
  // continue straight into it.
  assign other_loaded = loaded[~switch] | (wr_half_done && (wr_half == ~switch));

`ifdef DA_CHE_REPEAT_EN
  assign release_half = half_done && other_loaded;
`else
  assign release_half = half_done;
`endif

  // Look one cycle ahead so a word arriving while the final entry write is
  // pending is not accepted into a half that is about to become full.
  assign eff_loaded0 = (loaded[0] && !(release_half && !switch)) ||
                       (wr_half_done && !wr_half);
  assign eff_loaded1 = (loaded[1] && !(release_half && switch)) ||
                       (wr_half_done && wr_half);
  assign wready      = !(eff_loaded0 && eff_loaded1);

  assign slot = slot_sel ? ram_q[SLOT_NBIT-1:0]
                         : ram_q[DA_CHE_DATA_NBIT-1:SLOT_NBIT];

  pingpong_ram #(
    .AW(CHE_ADDR_NBIT + 1),
    .DW(DA_CHE_DATA_NBIT)
  ) u_ram (
    .clk   (clk),
    .we    (wr_pend),
    .waddr ({wr_half, wr_addr}),
    .wdata (wr_entry),
    .re    (state == RD_FETCH),
    .raddr ({switch, rd_addr}),
    .rdata (ram_q)
  );

  // Set and clear may hit different halves in the same cycle.
  always_comb begin
    loaded_nxt = loaded;
    if (release_half) loaded_nxt[switch]  = 1'b0;
    if (wr_half_done) loaded_nxt[wr_half] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= '0;
    end else if (!en) begin
      loaded <= '0;
    end else begin
      loaded <= loaded_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt <= '0;
      pack_buf <= '0;
      wr_entry <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_half  <= 1'b0;
      overrun  <= 1'b0;
    end else if (!en) begin
      pack_cnt <= '0;
      pack_buf <= '0;
      wr_entry <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_half  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (wr) begin
        if (wready) begin
          case (pack_cnt)
            2'd0: begin
              pack_buf[2*USB_DATA_NBIT-1:USB_DATA_NBIT] <= wdata;
              pack_cnt <= 2'd1;
            end
            2'd1: begin
              pack_buf[USB_DATA_NBIT-1:0] <= wdata;
              pack_cnt <= 2'd2;
            end
            default: begin
              wr_entry <= {pack_buf, wdata};
              wr_pend  <= 1'b1;
              pack_cnt <= 2'd0;
            end
          endcase
        end else begin
          overrun <= 1'b1;
        end
      end
      if (wr_pend) wr_addr <= wr_addr + 1'b1;
      if (wr_half_done) wr_half <= ~wr_half;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RD_IDLE;
      rd_addr   <= '0;
      slot_sel  <= 1'b0;
      switch    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      underflow <= 1'b0;
    end else if (!en) begin
      state     <= RD_IDLE;
      rd_addr   <= '0;
      slot_sel  <= 1'b0;
      switch    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // two-stage output pipeline gives the fixed rd -> rvalid latency
      s1_valid <= rd;
      rvalid   <= s1_valid;
      if (s1_valid) rdata <= s1_data;
      if (rd) begin
        if (state == RD_PLAY) begin
          s1_data <= DA_DATA_NBIT'(slot);
        end else begin
          s1_data   <= '0;
          underflow <= 1'b1;
        end
      end

      case (state)
        RD_IDLE: begin
          if (loaded[switch]) begin
            state <= RD_FETCH;
          end else if (loaded[~switch]) begin
            switch <= ~switch;
            state  <= RD_FETCH;
          end
        end
        RD_FETCH: state <= RD_PLAY;
        RD_PLAY: begin
          if (play_rd) begin
            slot_sel <= ~slot_sel;
            if (slot_sel) begin
              if (rd_addr != '1) begin
                rd_addr <= rd_addr + 1'b1;
                state   <= RD_FETCH;
              end else begin
                rd_addr <= '0;
                if (release_half) switch <= ~switch;
                // without a release the same half is replayed
                state <= (release_half && !other_loaded) ? RD_IDLE : RD_FETCH;
              end
            end
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule
